// File: rtl/ex_stage_mem_reg.sv
// Execute stage: operand select, optional forwarding, ALU, EX/MEM register.
// Optional macro EX_FWD_EN enables EX/MEM and MEM/WB forwarding on rs1/rs2.
// Ports: ID_EX_* bundle in, MEM_WB_* forwarding source, flush, EX_MEM_* out.
module ex_stage_mem_reg #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [REG_WIDTH-1:0]      ID_EX_pc,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
  input  logic [REG_WIDTH-1:0]      ID_EX_data_out_1,
  input  logic [REG_WIDTH-1:0]      ID_EX_data_out_2,
  input  logic [REG_WIDTH-1:0]      ID_EX_imm_out,
  input  logic [2:0]                ID_EX_alu_sel,
  input  logic                      ID_EX_ASel,
  input  logic                      ID_EX_BSel,
  input  logic                      ID_EX_reg_write_en,
  input  logic                      ID_EX_mem_write_en,
  input  logic                      ID_EX_wb_sel,
  input  logic [REG_ADDR_WIDTH-1:0] MEM_WB_rd,
  input  logic                      MEM_WB_reg_write_en,
  input  logic [REG_WIDTH-1:0]      MEM_WB_wb_data,
  input  logic                      flush,
  output logic [REG_WIDTH-1:0]      EX_MEM_alu_out,
  output logic [REG_WIDTH-1:0]      EX_MEM_store_data,
  output logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
  output logic                      EX_MEM_reg_write_en,
  output logic                      EX_MEM_mem_write_en,
  output logic                      EX_MEM_wb_sel
);

  localparam int SHW = $clog2(REG_WIDTH);

  logic [REG_WIDTH-1:0]      alu_out_q, alu_out_d;
  logic [REG_WIDTH-1:0]      store_data_q, store_data_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      reg_we_q, reg_we_d;
  logic                      mem_we_q, mem_we_d;
  logic                      wb_sel_q, wb_sel_d;

  logic [REG_WIDTH-1:0] rs1_val;
  logic [REG_WIDTH-1:0] rs2_val;
  logic [REG_WIDTH-1:0] op_a;
  logic [REG_WIDTH-1:0] op_b;
  logic [REG_WIDTH-1:0] alu_res;
  logic [SHW-1:0]       shamt;

`ifdef EX_FWD_EN
  logic ex_hit1, ex_hit2, wb_hit1, wb_hit2;
  logic ex_src_ok, wb_src_ok;

  // x0 is never a forwarding source; a flushed entry has reg_we_q = 0
  assign ex_src_ok = reg_we_q && (rd_q != '0);
  assign wb_src_ok = MEM_WB_reg_write_en && (MEM_WB_rd != '0);
  assign ex_hit1   = ex_src_ok && (rd_q == ID_EX_rs1);
  assign ex_hit2   = ex_src_ok && (rd_q == ID_EX_rs2);
  assign wb_hit1   = wb_src_ok && (MEM_WB_rd == ID_EX_rs1);
  assign wb_hit2   = wb_src_ok && (MEM_WB_rd == ID_EX_rs2);

  // EX/MEM holds the newer value, so it is checked first
  always_comb begin
    rs1_val = ID_EX_data_out_1;
    if (ex_hit1)      rs1_val = alu_out_q;
    else if (wb_hit1) rs1_val = MEM_WB_wb_data;
  end

  always_comb begin
    rs2_val = ID_EX_data_out_2;
    if (ex_hit2)      rs2_val = alu_out_q;
    else if (wb_hit2) rs2_val = MEM_WB_wb_data;
  end
`else
  logic unused_fwd;

  assign rs1_val    = ID_EX_data_out_1;
  assign rs2_val    = ID_EX_data_out_2;
  assign unused_fwd = ^{MEM_WB_rd, MEM_WB_reg_write_en,
                        MEM_WB_wb_data, ID_EX_rs1, ID_EX_rs2};
`endif

  assign op_a  = ID_EX_ASel ? ID_EX_pc      : rs1_val;
  assign op_b  = ID_EX_BSel ? ID_EX_imm_out : rs2_val;
  assign shamt = op_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    unique case (ID_EX_alu_sel)
      3'd0: alu_res = op_a + op_b;
      3'd1: alu_res = op_a - op_b;
      3'd2: alu_res = op_a & op_b;
      3'd3: alu_res = op_a | op_b;
      3'd4: alu_res = op_a ^ op_b;
      3'd5: alu_res = op_a << shamt;
      3'd6: alu_res = op_a >> shamt;
      3'd7: alu_res = REG_WIDTH'($signed(op_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Flush kills only the control fields; data fields capture as usual
  always_comb begin
    alu_out_d    = alu_res;
    store_data_d = rs2_val;
    rd_d         = ID_EX_rd;
    reg_we_d     = ID_EX_reg_write_en && !flush;
    mem_we_d     = ID_EX_mem_write_en && !flush;
    wb_sel_d     = ID_EX_wb_sel && !flush;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_out_q    <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      reg_we_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      wb_sel_q     <= 1'b0;
    end else begin
      alu_out_q    <= alu_out_d;
      store_data_q <= store_data_d;
      rd_q         <= rd_d;
      reg_we_q     <= reg_we_d;
      mem_we_q     <= mem_we_d;
      wb_sel_q     <= wb_sel_d;
    end
  end

  assign EX_MEM_alu_out      = alu_out_q;
  assign EX_MEM_store_data   = store_data_q;
  assign EX_MEM_rd           = rd_q;
  assign EX_MEM_reg_write_en = reg_we_q;
  assign EX_MEM_mem_write_en = mem_we_q;
  assign EX_MEM_wb_sel       = wb_sel_q;

endmodule

// File: tb/tb_ex_stage_mem_reg.sv
// Testbench for ex_stage_mem_reg: scoreboard of expected EX/MEM contents.
// Forwarding scenarios follow the EX_FWD_EN build setting.
module tb_ex_stage_mem_reg;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rwe;
    logic        mwe;
    logic        wbs;
  } out_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pc = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [4:0]  rd = '0;
  logic [31:0] d1 = '0;
  logic [31:0] d2 = '0;
  logic [31:0] imm = '0;
  logic [2:0]  sel = '0;
  logic        asel = 1'b0;
  logic        bsel = 1'b0;
  logic        rwe = 1'b0;
  logic        mwe = 1'b0;
  logic        wbs = 1'b0;
  logic [4:0]  mw_rd = '0;
  logic        mw_we = 1'b0;
  logic [31:0] mw_data = '0;
  logic        fl = 1'b0;

  logic [31:0] o_alu, o_sd;
  logic [4:0]  o_rd;
  logic        o_rwe, o_mwe, o_wbs;

  int   n_total = 0;
  int   n_pass = 0;
  out_t sb[$];
  out_t got, exp_v;

  always #5 clk = ~clk;

  ex_stage_mem_reg dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .ID_EX_pc            (pc),
    .ID_EX_rs1           (rs1),
    .ID_EX_rs2           (rs2),
    .ID_EX_rd            (rd),
    .ID_EX_data_out_1    (d1),
    .ID_EX_data_out_2    (d2),
    .ID_EX_imm_out       (imm),
    .ID_EX_alu_sel       (sel),
    .ID_EX_ASel          (asel),
    .ID_EX_BSel          (bsel),
    .ID_EX_reg_write_en  (rwe),
    .ID_EX_mem_write_en  (mwe),
    .ID_EX_wb_sel        (wbs),
    .MEM_WB_rd           (mw_rd),
    .MEM_WB_reg_write_en (mw_we),
    .MEM_WB_wb_data      (mw_data),
    .flush               (fl),
    .EX_MEM_alu_out      (o_alu),
    .EX_MEM_store_data   (o_sd),
    .EX_MEM_rd           (o_rd),
    .EX_MEM_reg_write_en (o_rwe),
    .EX_MEM_mem_write_en (o_mwe),
    .EX_MEM_wb_sel       (o_wbs)
  );

  function automatic out_t snap();
    return {o_alu, o_sd, o_rd, o_rwe, o_mwe, o_wbs};
  endfunction

  function automatic out_t mk(input logic [31:0] a, input logic [31:0] s,
                              input logic [4:0] r, input logic w,
                              input logic m, input logic b);
    return {a, s, r, w, m, b};
  endfunction

  // Drive one instruction at the falling edge and queue its expectation
  task automatic issue(input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rdi, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] op,
                       input logic w, input logic m, input logic ws,
                       input logic f, input out_t e);
    @(negedge clk);
    rs1 = r1; rs2 = r2; rd = rdi;
    d1 = a; d2 = b; sel = op;
    rwe = w; mwe = m; wbs = ws; fl = f;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    got = snap();
    n_total++;
    if (got !== '0) $display("FAIL reset_init got=%h exp=0", got);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    issue(1, 2, 4, 32'h11, 32'h22, 3'd0, 1, 1, 1, 0,
          mk(32'h33, 32'h22, 4, 1, 1, 1));
    got = snap();
    exp_v = (sb.size() != 0) ? sb.pop_front() : '1;
    n_total++;
    if (got !== exp_v) $display("FAIL pre_reset got=%h exp=%h", got, exp_v);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    got = snap();
    n_total++;
    if (got !== '0) $display("FAIL async_reset got=%h exp=0", got);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    issue(1, 2, 3, 32'd5, 32'd7, 3'd0, 1, 0, 0, 0,
          mk(32'd12, 32'd7, 3, 1, 0, 0));
    got = snap();
    exp_v = (sb.size() != 0) ? sb.pop_front() : '1;
    n_total++;
    if (got !== exp_v) $display("FAIL post_reset got=%h exp=%h", got, exp_v);
    else n_pass++;
  endtask

  task automatic test_alu_sweep();
    logic [2:0]  ops[7];
    logic [31:0] res[7];
    ops = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    res = '{32'h7FFFFFE3, 32'h00000000, 32'h80000025, 32'h80000025,
            32'h00000008, 32'h40000002, 32'hC0000002};
    for (int i = 0; i < 7; i++) begin
      issue(1, 2, 10, 32'h80000004, 32'h21, ops[i], 1, 0, 0, 0,
            mk(res[i], 32'h21, 10, 1, 0, 0));
      got = snap();
      exp_v = (sb.size() != 0) ? sb.pop_front() : '1;
      n_total++;
      if (got !== exp_v)
        $display("FAIL alu_op%0d got=%h exp=%h", ops[i], got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_operand_mux();
    @(negedge clk);
    pc = 32'h100; imm = 32'h10; asel = 1; bsel = 1;
    issue(1, 6, 11, 32'h5555, 32'hDEAD, 3'd0, 1, 1, 0, 0,
          mk(32'h110, 32'hDEAD, 11, 1, 1, 0));
    got = snap();
    exp_v = (sb.size() != 0) ? sb.pop_front() : '1;
    n_total++;
    if (got !== exp_v) $display("FAIL operand_mux got=%h exp=%h", got, exp_v);
    else n_pass++;
    @(negedge clk);
    pc = '0; imm = '0; asel = 0; bsel = 0;
  endtask

`ifdef EX_FWD_EN
  task automatic test_forwarding();
    out_t e[6];
    e[0] = mk(32'd9, 32'd5, 5, 1, 0, 0);
    e[1] = mk(32'd9, 32'd0, 6, 1, 0, 0);
    e[2] = mk(32'd3, 32'd2, 7, 1, 0, 0);
    e[3] = mk(32'd50, 32'd0, 0, 1, 0, 0);
    e[4] = mk(32'd8, 32'd1, 8, 1, 0, 0);
    e[5] = mk(32'h44, 32'd8, 9, 0, 1, 0);
    issue(1, 2, 5, 32'd4, 32'd5, 3'd0, 1, 0, 0, 0, e[0]);
    got = snap();
    exp_v = (sb.size() != 0) ? sb.pop_front() : '1;
    n_total++;
    if (got !== exp_v) $display("FAIL fwd_prod got=%h exp=%h", got, exp_v);
    else n_pass++;
    @(negedge clk);
    mw_rd = 5; mw_we = 1; mw_data = 32'd1;
    issue(5, 12, 6, 32'd100, 32'd0, 3'd0, 1, 0, 0, 0, e[1]);
    got = snap();
    exp_v = (sb.size() != 0) ? sb.pop_front() : '1;
    n_total++;
    if (got !== exp_v) $display("FAIL fwd_exmem_wins got=%h exp=%h", got, exp_v);
    else n_pass++;
    issue(5, 13, 7, 32'd100, 32'd2, 3'd0, 1, 0, 0, 0, e[2]);
    got = snap();
    exp_v = (sb.size() != 0) ? sb.pop_front() : '1;
    n_total++;
    if (got !== exp_v) $display("FAIL fwd_memwb got=%h exp=%h", got, exp_v);
    else n_pass++;
    @(negedge clk);
    mw_rd = 0; mw_we = 1; mw_data = 32'd99;
    issue(1, 2, 0, 32'd50, 32'd0, 3'd0, 1, 0, 0, 0, e[3]);
    got = snap();
    exp_v = (sb.size() != 0) ? sb.pop_front() : '1;
    n_total++;
    if (got !== exp_v) $display("FAIL fwd_x0_prod got=%h exp=%h", got, exp_v);
    else n_pass++;
    issue(0, 0, 8, 32'd7, 32'd1, 3'd0, 1, 0, 0, 0, e[4]);
    got = snap();
    exp_v = (sb.size() != 0) ? sb.pop_front() : '1;
    n_total++;
    if (got !== exp_v) $display("FAIL fwd_x0_none got=%h exp=%h", got, exp_v);
    else n_pass++;
    @(negedge clk);
    mw_we = 0; bsel = 1; imm = 32'h4;
    issue(1, 8, 9, 32'h40, 32'h55, 3'd0, 0, 1, 0, 0, e[5]);
    got = snap();
    exp_v = (sb.size() != 0) ? sb.pop_front() : '1;
    n_total++;
    if (got !== exp_v) $display("FAIL fwd_store got=%h exp=%h", got, exp_v);
    else n_pass++;
    @(negedge clk);
    bsel = 0; imm = '0;
  endtask
`else
  task automatic test_no_forward();
    issue(1, 2, 5, 32'd4, 32'd5, 3'd0, 1, 0, 0, 0,
          mk(32'd9, 32'd5, 5, 1, 0, 0));
    got = snap();
    exp_v = (sb.size() != 0) ? sb.pop_front() : '1;
    n_total++;
    if (got !== exp_v) $display("FAIL nofwd_prod got=%h exp=%h", got, exp_v);
    else n_pass++;
    @(negedge clk);
    mw_rd = 5; mw_we = 1; mw_data = 32'd1;
    issue(5, 5, 6, 32'd100, 32'd3, 3'd0, 1, 0, 0, 0,
          mk(32'd103, 32'd3, 6, 1, 0, 0));
    got = snap();
    exp_v = (sb.size() != 0) ? sb.pop_front() : '1;
    n_total++;
    if (got !== exp_v) $display("FAIL nofwd_use got=%h exp=%h", got, exp_v);
    else n_pass++;
    @(negedge clk);
    mw_we = 0; mw_rd = 0; mw_data = 0;
  endtask
`endif

  task automatic test_flush();
    issue(1, 2, 9, 32'd3, 32'd4, 3'd0, 1, 1, 1, 1,
          mk(32'd7, 32'd4, 9, 0, 0, 0));
    got = snap();
    exp_v = (sb.size() != 0) ? sb.pop_front() : '1;
    n_total++;
    if (got !== exp_v) $display("FAIL flush_bubble got=%h exp=%h", got, exp_v);
    else n_pass++;
    issue(9, 0, 14, 32'd20, 32'd1, 3'd0, 1, 0, 0, 0,
          mk(32'd21, 32'd1, 14, 1, 0, 0));
    got = snap();
    exp_v = (sb.size() != 0) ? sb.pop_front() : '1;
    n_total++;
    if (got !== exp_v) $display("FAIL flush_no_fwd got=%h exp=%h", got, exp_v);
    else n_pass++;
  endtask

  task automatic test_wrap();
    issue(12, 13, 11, 32'hFFFFFFFF, 32'd1, 3'd0, 1, 0, 0, 0,
          mk(32'h0, 32'd1, 11, 1, 0, 0));
    got = snap();
    exp_v = (sb.size() != 0) ? sb.pop_front() : '1;
    n_total++;
    if (got !== exp_v) $display("FAIL add_wrap got=%h exp=%h", got, exp_v);
    else n_pass++;
    issue(12, 13, 15, 32'd1, 32'h25, 3'd5, 1, 0, 0, 0,
          mk(32'h20, 32'h25, 15, 1, 0, 0));
    got = snap();
    exp_v = (sb.size() != 0) ? sb.pop_front() : '1;
    n_total++;
    if (got !== exp_v) $display("FAIL sll_mask got=%h exp=%h", got, exp_v);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu_sweep();
    test_operand_mux();
`ifdef EX_FWD_EN
    test_forwarding();
`else
    test_no_forward();
`endif
    test_flush();
    test_wrap();
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_drain got=%0d exp=0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
